// File: rtl/apple1_term_write_ctrl.sv
// ---------------------------------------------------------------------------
// apple1_term_write_ctrl
//
// Character-write sequencer for the Apple-1 video terminal. It accepts one
// character at a time from the PIA with a 4-phase da/rda handshake, classifies
// it, and then does one of three things:
//   - printable: writes it into the screen shift memory during the cursor cell
//     window, then advances the cursor column;
//   - carriage return: requests a new line/scroll from the scroll logic;
//   - other control characters: discards them.
// Writing into the last column wraps through the same new-line path as CR.
// This block owns the cursor column counter.
//
// Ports
//   cp       in   clock, rising edge
//   mr       in   synchronous active-high reset, dominates all other inputs
//   da       in   data available from PIA (level)
//   d[6:0]   in   ASCII character, valid while da=1
//   rda      out  ready for data (registered)
//   cur_win  in   one-cycle pulse when video timing reaches the cursor cell
//   wr_en    out  one-cycle screen write strobe (registered)
//   wr_char  out  6-bit Apple-1 display code, valid with wr_en
//   col      out  current cursor column, 0..COLS-1
//   nl_req   out  one-cycle new-line/scroll request (registered)
//   nl_done  in   one-cycle acknowledge from the scroll logic
//   busy     out  high in every state except IDLE
// ---------------------------------------------------------------------------
module apple1_term_write_ctrl #(
    parameter int COLS = 40
) (
    input  logic       cp,
    input  logic       mr,
    input  logic       da,
    input  logic [6:0] d,
    output logic       rda,
    input  logic       cur_win,
    output logic       wr_en,
    output logic [5:0] wr_char,
    output logic [5:0] col,
    output logic       nl_req,
    input  logic       nl_done,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        CLASSIFY = 3'd1,
        WAIT_WIN = 3'd2,
        WRITE    = 3'd3,
        NEWLINE  = 3'd4,
        WAIT_NL  = 3'd5,
        RELEASE  = 3'd6
    } state_t;

    localparam logic [5:0] LAST_COL = 6'(COLS - 1);
    localparam logic [6:0] ASCII_CR = 7'h0D;

    state_t     state;
    logic [6:0] h;

    // Classification of the held character; only meaningful in CLASSIFY.
    logic       is_cr;
    logic       is_ctrl;
    logic [5:0] disp_code;

    assign is_cr   = (h == ASCII_CR);
    assign is_ctrl = (h < 7'h20) && !is_cr;

    // 0x60..0x7F fold onto 0x40..0x5F, whose display code is h[5:0] with
    // bit 5 clear; everything else printable maps straight to h[5:0].
    assign disp_code = (h[6] && h[5]) ? {1'b0, h[4:0]} : h[5:0];

    assign busy = (state != IDLE);

    // wr_en and nl_req are set on entry to WRITE / NEWLINE and cleared on the
    // next edge, so each is high exactly for the single cycle spent in that
    // state and the two can never overlap.
    always_ff @(posedge cp) begin
        if (mr) begin
            state   <= IDLE;
            h       <= 7'h00;
            rda     <= 1'b1;
            wr_en   <= 1'b0;
            wr_char <= 6'h00;
            nl_req  <= 1'b0;
            col     <= 6'd0;
        end else begin
            wr_en  <= 1'b0;
            nl_req <= 1'b0;

            case (state)
                IDLE: begin
                    if (da) begin
                        h     <= d;
                        rda   <= 1'b0;
                        state <= CLASSIFY;
                    end
                end

                CLASSIFY: begin
                    if (is_cr) begin
                        nl_req <= 1'b1;
                        col    <= 6'd0;
                        state  <= NEWLINE;
                    end else if (is_ctrl) begin
                        state <= RELEASE;
                    end else begin
                        state <= WAIT_WIN;
                    end
                end

                // cur_win is only honoured here; pulses seen in any other
                // state are dropped and the write waits for the next one.
                WAIT_WIN: begin
                    if (cur_win) begin
                        wr_en   <= 1'b1;
                        wr_char <= disp_code;
                        state   <= WRITE;
                    end
                end

                WRITE: begin
                    if (col == LAST_COL) begin
                        col    <= 6'd0;
                        nl_req <= 1'b1;
                        state  <= NEWLINE;
                    end else begin
                        col   <= col + 6'd1;
                        state <= RELEASE;
                    end
                end

                // nl_req is high during this cycle; an nl_done arriving now
                // belongs to nothing and is ignored.
                NEWLINE: begin
                    col   <= 6'd0;
                    state <= WAIT_NL;
                end

                WAIT_NL: begin
                    if (nl_done) begin
                        state <= RELEASE;
                    end
                end

                // Hold rda low until the PIA drops da, so a da that stays
                // high can never trigger a second capture.
                RELEASE: begin
                    if (!da) begin
                        rda   <= 1'b1;
                        state <= IDLE;
                    end
                end

                default: begin
                    rda   <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apple1_term_write_ctrl.sv
module tb_apple1_term_write_ctrl;

    logic       cp = 1'b0;
    logic       mr = 1'b1;
    logic       da = 1'b0;
    logic [6:0] d = 7'h00;
    logic       rda;
    logic       cur_win = 1'b0;
    logic       wr_en;
    logic [5:0] wr_char;
    logic [5:0] col;
    logic       nl_req;
    logic       nl_done = 1'b0;
    logic       busy;

    int total = 0;
    int bad = 0;
    int wr_cnt = 0;
    int nl_cnt = 0;
    int both_cnt = 0;
    int wr0, nl0;

    apple1_term_write_ctrl #(.COLS(40)) dut (
        .cp(cp), .mr(mr), .da(da), .d(d), .rda(rda), .cur_win(cur_win),
        .wr_en(wr_en), .wr_char(wr_char), .col(col), .nl_req(nl_req),
        .nl_done(nl_done), .busy(busy)
    );

    always #5 cp = ~cp;

    // Pulse counters: sample the previous cycle's outputs at each edge.
    always @(posedge cp) begin
        if (wr_en) wr_cnt++;
        if (nl_req) nl_cnt++;
        if (wr_en && nl_req) both_cnt++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge cp);
        #1;
    endtask

    // Full printable transaction with an immediate window; ends in IDLE.
    task automatic put_print(input logic [6:0] ch);
        da = 1'b1; d = ch;
        tick();                 // CLASSIFY
        tick();                 // WAIT_WIN
        cur_win = 1'b1;
        tick();                 // WRITE
        cur_win = 1'b0;
        da = 1'b0;
        tick();                 // RELEASE
        tick();                 // IDLE
    endtask

    task automatic do_reset();
        mr = 1'b1;
        tick();
        tick();
        mr = 1'b0;
    endtask

    initial begin
        // ---- reset state
        do_reset();
        chk("rst_rda", rda, 1);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_nl_req", nl_req, 0);
        chk("rst_col", col, 0);
        chk("rst_busy", busy, 0);

        // ---- printable 'A' with window 5 cycles later
        da = 1'b1; d = 7'h41;
        tick();
        chk("a_rda_fall", rda, 0);
        chk("a_busy", busy, 1);
        repeat (4) tick();
        chk("a_no_early_wr", wr_en, 0);
        cur_win = 1'b1;
        tick();
        cur_win = 1'b0;
        chk("a_wr_en", wr_en, 1);
        chk("a_wr_char", wr_char, 6'h01);
        chk("a_col_during", col, 0);
        da = 1'b0;
        tick();
        chk("a_wr_en_1cyc", wr_en, 0);
        chk("a_col_after", col, 1);
        chk("a_rda_still0", rda, 0);
        tick();
        chk("a_rda_rise", rda, 1);
        chk("a_wr_cnt", wr_cnt, 1);

        // ---- lower-case fold, cur_win during CLASSIFY ignored, long wait
        da = 1'b1; d = 7'h61;
        tick();                 // CLASSIFY
        cur_win = 1'b1;
        tick();                 // WAIT_WIN (pulse ignored)
        cur_win = 1'b0;
        repeat (200) tick();
        chk("lc_no_wr_wait", wr_cnt, 1);
        cur_win = 1'b1;
        tick();
        cur_win = 1'b0;
        chk("lc_wr_en", wr_en, 1);
        chk("lc_wr_char", wr_char, 6'h01);
        da = 1'b0;
        tick(); tick();
        chk("lc_rda", rda, 1);
        chk("lc_col", col, 2);

        // ---- wrap after 40 printables
        do_reset();
        wr0 = wr_cnt; nl0 = nl_cnt;
        for (int i = 0; i < 39; i++) put_print(7'h30 + 7'(i % 10));
        chk("wrap_col39", col, 39);
        da = 1'b1; d = 7'h5A;
        tick(); tick();
        cur_win = 1'b1;
        tick();
        cur_win = 1'b0;
        chk("wrap_wr_en", wr_en, 1);
        chk("wrap_wr_char", wr_char, 6'h1A);
        tick();                 // NEWLINE
        chk("wrap_nl_req", nl_req, 1);
        chk("wrap_no_wr", wr_en, 0);
        chk("wrap_col0", col, 0);
        tick();                 // WAIT_NL
        chk("wrap_nl_1cyc", nl_req, 0);
        tick();
        nl_done = 1'b1;
        tick();                 // RELEASE
        nl_done = 1'b0;
        repeat (5) tick();
        chk("wrap_rda_held", rda, 0);
        da = 1'b0;
        tick();
        chk("wrap_rda_rise", rda, 1);
        chk("wrap_wr_cnt", wr_cnt - wr0, 40);
        chk("wrap_nl_cnt", nl_cnt - nl0, 1);

        // ---- CR at column 7, early nl_done ignored
        do_reset();
        for (int i = 0; i < 7; i++) put_print(7'h2A);
        chk("cr_col7", col, 7);
        wr0 = wr_cnt; nl0 = nl_cnt;
        da = 1'b1; d = 7'h0D;
        tick(); tick();         // NEWLINE
        chk("cr_nl_req", nl_req, 1);
        chk("cr_col0", col, 0);
        nl_done = 1'b1;         // coincides with nl_req: must be ignored
        tick();                 // WAIT_NL
        nl_done = 1'b0;
        da = 1'b0;
        tick(); tick();
        chk("cr_wait_nl_held", rda, 0);
        nl_done = 1'b1;
        tick();                 // RELEASE
        nl_done = 1'b0;
        tick();                 // IDLE
        chk("cr_rda", rda, 1);
        chk("cr_no_wr", wr_cnt - wr0, 0);
        chk("cr_nl_cnt", nl_cnt - nl0, 1);

        // ---- BEL control character discarded
        wr0 = wr_cnt; nl0 = nl_cnt;
        da = 1'b1; d = 7'h07;
        tick(); tick();         // RELEASE
        cur_win = 1'b1;
        tick();
        cur_win = 1'b0;
        da = 1'b0;
        tick();
        chk("bel_rda", rda, 1);
        chk("bel_no_wr", wr_cnt - wr0, 0);
        chk("bel_no_nl", nl_cnt - nl0, 0);
        chk("bel_col", col, 0);

        // ---- da held high 100 cycles after the write
        wr0 = wr_cnt;
        da = 1'b1; d = 7'h42;
        tick(); tick();
        cur_win = 1'b1;
        tick();
        cur_win = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cur_win = (i % 10 == 5);
            tick();
        end
        cur_win = 1'b0;
        chk("hold_rda", rda, 0);
        chk("hold_one_wr", wr_cnt - wr0, 1);
        da = 1'b0;
        tick();
        chk("hold_rda_rise", rda, 1);
        chk("hold_col", col, 1);

        // ---- reset in WAIT_WIN, then da still high re-captures
        wr0 = wr_cnt; nl0 = nl_cnt;
        da = 1'b1; d = 7'h43;
        tick(); tick();         // WAIT_WIN
        mr = 1'b1;
        cur_win = 1'b1;
        tick();
        mr = 1'b0;
        cur_win = 1'b0;
        chk("mrw_rda", rda, 1);
        chk("mrw_col", col, 0);
        chk("mrw_wr_en", wr_en, 0);
        tick();
        chk("mrw_recapture", rda, 0);
        chk("mrw_recap_busy", busy, 1);
        mr = 1'b1;
        tick();
        mr = 1'b0;
        da = 1'b0;
        tick();

        // ---- reset in WAIT_NL
        da = 1'b1; d = 7'h0D;
        tick(); tick(); tick(); // WAIT_NL
        mr = 1'b1;
        nl_done = 1'b1;
        tick();
        mr = 1'b0;
        nl_done = 1'b0;
        da = 1'b0;
        chk("mrn_nl_req", nl_req, 0);
        chk("mrn_rda", rda, 1);
        chk("mrn_busy", busy, 0);
        repeat (5) tick();
        chk("mrn_no_wr", wr_cnt - wr0, 0);
        chk("mrn_nl_cnt", nl_cnt - nl0, 1);
        chk("mrn_col", col, 0);

        chk("never_both", both_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case something above stalls.
    initial begin
        #200000;
        $display("FAIL timeout: got 1 want 0");
        $fatal(1, "timeout");
    end

endmodule
